// File: rtl/if_id_stage.sv
// Fetch-to-decode stage: two-entry skid buffer (MAIN drives the outputs, SKID absorbs
// one extra word under back-pressure) with opcode pre-decode done on the write path.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [2:0]  R_FORMAT  = 3'b000,
  parameter logic [2:0]  I_FORMAT  = 3'b001,
  parameter logic [2:0]  S_FORMAT  = 3'b010,
  parameter logic [2:0]  U_FORMAT  = 3'b011,
  parameter logic [2:0]  SB_FORMAT = 3'b100,
  parameter logic [2:0]  UJ_FORMAT = 3'b101
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] INSTR_IN,
  input  logic [31:0] PC_IN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        FLUSH,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT,
  output logic [24:0] IMM_INPUT,
  output logic [2:0]  IMM_FORMAT,
  output logic [4:0]  RS1_ADDR,
  output logic [4:0]  RS2_ADDR,
  output logic [4:0]  RD_ADDR,
  output logic        ILLEGAL
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic [31:0] r_main_instr, r_main_pc, r_skid_instr, r_skid_pc;
  logic [2:0]  r_main_fmt, r_skid_fmt;
  logic        r_main_ill, r_skid_ill;

  logic        w_acc, w_pop;
  logic [3:0]  w_in_dec;

  // Returns {illegal, format}; a bad low-bit pair or unknown opcode decodes as illegal R.
  function automatic logic [3:0] predecode(input logic [6:0] op);
    logic [3:0] d;
    d = {1'b0, R_FORMAT};
    case (op)
      7'b0110011:                                     d = {1'b0, R_FORMAT};
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                         d = {1'b0, I_FORMAT};
      7'b0100011:                                     d = {1'b0, S_FORMAT};
      7'b0110111, 7'b0010111:                         d = {1'b0, U_FORMAT};
      7'b1100011:                                     d = {1'b0, SB_FORMAT};
      7'b1101111:                                     d = {1'b0, UJ_FORMAT};
      default:                                        d = {1'b1, R_FORMAT};
    endcase
    return d;
  endfunction

  assign w_in_dec  = predecode(INSTR_IN[6:0]);
  assign w_acc     = IN_VALID & r_in_ready;
  assign w_pop     = OUT_VALID & OUT_READY;

  assign OUT_VALID  = (r_state != S_EMPTY);
  assign IN_READY   = r_in_ready;
  assign INSTR_OUT  = r_main_instr;
  assign PC_OUT     = r_main_pc;
  assign IMM_INPUT  = r_main_instr[31:7];
  assign IMM_FORMAT = r_main_fmt;
  assign RS1_ADDR   = r_main_instr[19:15];
  assign RS2_ADDR   = r_main_instr[24:20];
  assign RD_ADDR    = r_main_instr[11:7];
  assign ILLEGAL    = r_main_ill;

  // MAIN is reloaded with the NOP image whenever the buffer empties, so outputs need no mux.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_EMPTY;
      r_in_ready   <= 1'b1;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= '0;
      r_main_fmt   <= I_FORMAT;
      r_main_ill   <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_fmt   <= I_FORMAT;
      r_skid_ill   <= 1'b0;
    end else if (FLUSH) begin
      r_state      <= S_EMPTY;
      r_in_ready   <= 1'b1;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= '0;
      r_main_fmt   <= I_FORMAT;
      r_main_ill   <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_state      <= S_ONE;
            r_main_instr <= INSTR_IN;
            r_main_pc    <= PC_IN;
            r_main_fmt   <= w_in_dec[2:0];
            r_main_ill   <= w_in_dec[3];
          end
        end
        S_ONE: begin
          if (w_acc && w_pop) begin
            r_main_instr <= INSTR_IN;
            r_main_pc    <= PC_IN;
            r_main_fmt   <= w_in_dec[2:0];
            r_main_ill   <= w_in_dec[3];
          end else if (w_acc) begin
            r_state      <= S_TWO;
            r_in_ready   <= 1'b0;
            r_skid_instr <= INSTR_IN;
            r_skid_pc    <= PC_IN;
            r_skid_fmt   <= w_in_dec[2:0];
            r_skid_ill   <= w_in_dec[3];
          end else if (w_pop) begin
            r_state      <= S_EMPTY;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_main_fmt   <= I_FORMAT;
            r_main_ill   <= 1'b0;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_state      <= S_ONE;
            r_in_ready   <= 1'b1;
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_fmt   <= r_skid_fmt;
            r_main_ill   <= r_skid_ill;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: queue-based reference model checked every cycle, plus
// hand-computed literal checks for each directed scenario.
module tb_if_id_stage;

  logic        CLK, RST_N;
  logic [31:0] INSTR_IN, PC_IN;
  logic        IN_VALID, IN_READY, FLUSH, OUT_READY, OUT_VALID;
  logic [31:0] INSTR_OUT, PC_OUT;
  logic [24:0] IMM_INPUT;
  logic [2:0]  IMM_FORMAT;
  logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
  logic        ILLEGAL;

  int n_chk  = 0;
  int n_fail = 0;

  if_id_stage dut (
    .CLK(CLK), .RST_N(RST_N), .INSTR_IN(INSTR_IN), .PC_IN(PC_IN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FLUSH(FLUSH), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .INSTR_OUT(INSTR_OUT), .PC_OUT(PC_OUT),
    .IMM_INPUT(IMM_INPUT), .IMM_FORMAT(IMM_FORMAT), .RS1_ADDR(RS1_ADDR),
    .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR), .ILLEGAL(ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is simply an ordered queue of accepted words (max 2).
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t q[$];
  logic m_rdy = 1'b1;

  function automatic logic [3:0] ref_fmt(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h33) return 4'h0;
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F) return 4'h1;
    if (op == 7'h23) return 4'h2;
    if (op == 7'h37 || op == 7'h17) return 4'h3;
    if (op == 7'h63) return 4'h4;
    if (op == 7'h6F) return 4'h5;
    return 4'h8;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      bit acc, pop;
      acc = IN_VALID && m_rdy;
      pop = (q.size() > 0) && OUT_READY;
      if (FLUSH) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{INSTR_IN, PC_IN});
      end
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge CLK) begin
    logic [31:0] ei, ep;
    logic [3:0]  ed;
    ei = (q.size() > 0) ? q[0].instr : 32'h00000013;
    ep = (q.size() > 0) ? q[0].pc : 32'h0;
    ed = ref_fmt(ei);
    chk("m_out_valid", {31'd0, OUT_VALID}, {31'd0, q.size() > 0});
    chk("m_in_ready", {31'd0, IN_READY}, {31'd0, m_rdy});
    chk("m_instr", INSTR_OUT, ei);
    chk("m_pc", PC_OUT, ep);
    chk("m_imm", {7'd0, IMM_INPUT}, {7'd0, ei[31:7]});
    chk("m_fmt", {29'd0, IMM_FORMAT}, {29'd0, ed[2:0]});
    chk("m_ill", {31'd0, ILLEGAL}, {31'd0, ed[3]});
    chk("m_regs", {17'd0, RS1_ADDR, RS2_ADDR, RD_ADDR}, {17'd0, ei[19:15], ei[24:20], ei[11:7]});
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    IN_VALID = v; INSTR_IN = ins; PC_IN = pc; OUT_READY = ordy; FLUSH = fl;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] sw_word [6];
  logic [3:0]  sw_exp  [6];

  initial begin
    sw_word = '{32'h000000B7, 32'h00000063, 32'h0000006F, 32'h00000033, 32'h0000007F, 32'hFFFFFFFC};
    sw_exp  = '{4'h3, 4'h4, 4'h5, 4'h0, 4'h8, 4'h8};
    RST_N = 1'b1; IN_VALID = 0; INSTR_IN = 0; PC_IN = 0; OUT_READY = 0; FLUSH = 0;
    #1 RST_N = 1'b0;
    #1;
    chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_ready", {31'd0, IN_READY}, 32'd1);
    chk("rst_instr", INSTR_OUT, 32'h00000013);
    chk("rst_fmt", {29'd0, IMM_FORMAT}, 32'd1);
    @(posedge CLK); @(posedge CLK); #1 RST_N = 1'b1;

    // Streaming addi then sw
    cyc(1, 32'h00500093, 32'h0, 1, 0);
    chk("s1_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("s1_fmt", {29'd0, IMM_FORMAT}, 32'd1);
    chk("s1_rd", {27'd0, RD_ADDR}, 32'd1);
    chk("s1_imm", {7'd0, IMM_INPUT}, 32'h0000A001);
    cyc(1, 32'h00112023, 32'h4, 1, 0);
    chk("s2_valid", {31'd0, OUT_VALID}, 32'd1);
    chk("s2_fmt", {29'd0, IMM_FORMAT}, 32'd2);
    chk("s2_rs2", {27'd0, RS2_ADDR}, 32'd1);
    chk("s2_pc", PC_OUT, 32'h4);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("s3_empty", {31'd0, OUT_VALID}, 32'd0);

    // Back-pressure
    cyc(1, 32'h00100093, 32'h10, 0, 0);
    cyc(1, 32'h00200113, 32'h14, 0, 0);
    chk("bp_ready0", {31'd0, IN_READY}, 32'd0);
    cyc(1, 32'h00300193, 32'h18, 0, 0);
    chk("bp_hold_pc", PC_OUT, 32'h10);
    cyc(1, 32'h00300193, 32'h18, 1, 0);
    chk("bp_pc2", PC_OUT, 32'h14);
    chk("bp_ready1", {31'd0, IN_READY}, 32'd1);
    cyc(1, 32'h00300193, 32'h18, 1, 0);
    chk("bp_pc3", PC_OUT, 32'h18);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Format sweep
    for (int i = 0; i < 6; i++) begin
      cyc(1, sw_word[i], 32'h100 + 4 * i, 1, 0);
      chk("sweep_fmt", {29'd0, IMM_FORMAT}, {29'd0, sw_exp[i][2:0]});
      chk("sweep_ill", {31'd0, ILLEGAL}, {31'd0, sw_exp[i][3]});
    end
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Flush in TWO with IN_VALID high, then flush in ONE with an accept
    cyc(1, 32'h00400213, 32'h20, 0, 0);
    cyc(1, 32'h00500293, 32'h24, 0, 0);
    cyc(1, 32'h00600313, 32'h28, 0, 1);
    chk("fl_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("fl_ready", {31'd0, IN_READY}, 32'd1);
    chk("fl_instr", INSTR_OUT, 32'h00000013);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("fl_gone", {31'd0, OUT_VALID}, 32'd0);
    cyc(1, 32'h00400213, 32'h30, 0, 0);
    cyc(1, 32'h00500293, 32'h34, 1, 1);
    chk("fl1_valid", {31'd0, OUT_VALID}, 32'd0);

    // Accept and pop together in ONE
    cyc(1, 32'h00A00113, 32'h50, 0, 0);
    cyc(1, 32'h00B00193, 32'h54, 1, 0);
    chk("ap_pc", PC_OUT, 32'h54);
    chk("ap_ready", {31'd0, IN_READY}, 32'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("ap_empty", {31'd0, OUT_VALID}, 32'd0);

    // Asynchronous reset mid-cycle while in TWO
    cyc(1, 32'h00400213, 32'h60, 0, 0);
    cyc(1, 32'h00500293, 32'h64, 0, 0);
    #2 RST_N = 1'b0;
    IN_VALID = 0;
    #1;
    chk("ar_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("ar_ready", {31'd0, IN_READY}, 32'd1);
    chk("ar_instr", INSTR_OUT, 32'h00000013);
    chk("ar_pc", PC_OUT, 32'h0);
    @(posedge CLK); #1 RST_N = 1'b1;
    cyc(1, 32'h00700313, 32'h70, 1, 0);
    chk("ar_first_pc", PC_OUT, 32'h70);
    chk("ar_first_instr", INSTR_OUT, 32'h00700313);
    cyc(0, 32'h0, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
